// File: rtl/sme_feeder.sv
// Host-side driver for the string-matching engine: buffers a string and a pattern,
// streams them over the chardata/isstring/ispattern link and captures the engine result.
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [5:0] str_len,
  input  logic [3:0] pat_len,
  input  logic       send_str,
  input  logic       start,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       res_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SEND_STR = 3'd1,
    ST_SEND_PAT = 3'd2,
    ST_WAIT     = 3'd3,
    ST_REPORT   = 3'd4
  } state_t;

  localparam logic [5:0] STR_MAX_C = 6'(STR_MAX);
  localparam logic [3:0] PAT_MAX_C = 4'(PAT_MAX);
  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  state_t     state_r;
  logic [5:0] idx_r;
  logic [5:0] str_len_r;
  logic [3:0] pat_len_r;
  logic [9:0] wdog_r;

  logic [7:0] str_buf_r [STR_MAX];
  logic [7:0] pat_buf_r [PAT_MAX];

  logic       wr_ok_s;
  logic       start_ok_s;
  logic       send_str_eff_s;
  logic [5:0] str_len_eff_s;
  logic [3:0] pat_len_eff_s;
  logic [7:0] first_str_s;
  logic [7:0] first_pat_s;
  logic [7:0] str_char_s;
  logic [7:0] pat_char_s;

  // Job qualification, length clamping and char selection for the sender.
  always_comb begin
    wr_ok_s        = wr_en && (state_r == ST_IDLE);
    start_ok_s     = start && (state_r == ST_IDLE) && (pat_len != 4'd0);
    send_str_eff_s = send_str && (str_len != 6'd0);
    str_len_eff_s  = (str_len > STR_MAX_C) ? STR_MAX_C : str_len;
    pat_len_eff_s  = (pat_len > PAT_MAX_C) ? PAT_MAX_C : pat_len;
    // A write landing on the start edge must already be visible in the first char.
    first_str_s    = (wr_ok_s && !wr_sel && (wr_addr == 5'd0)) ? wr_data : str_buf_r[0];
    first_pat_s    = (wr_ok_s && wr_sel && (wr_addr[2:0] == 3'd0)) ? wr_data : pat_buf_r[0];
    str_char_s     = str_buf_r[idx_r[4:0]];
    pat_char_s     = pat_buf_r[idx_r[2:0]];
  end

  // Character buffers; deliberately not reset so contents survive between jobs.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      if (wr_sel) begin
        pat_buf_r[wr_addr[2:0]] <= wr_data;
      end else begin
        str_buf_r[wr_addr] <= wr_data;
      end
    end
  end

  // Job sequencer with registered link and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      idx_r       <= 6'd0;
      str_len_r   <= 6'd0;
      pat_len_r   <= 4'd0;
      wdog_r      <= 10'd0;
      busy        <= 1'b0;
      chardata    <= 8'd0;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 5'd0;
      res_timeout <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            busy      <= 1'b1;
            str_len_r <= str_len_eff_s;
            pat_len_r <= pat_len_eff_s;
            idx_r     <= 6'd1;
            if (send_str_eff_s) begin
              state_r  <= ST_SEND_STR;
              isstring <= 1'b1;
              chardata <= first_str_s;
            end else begin
              state_r   <= ST_SEND_PAT;
              ispattern <= 1'b1;
              chardata  <= first_pat_s;
            end
          end
        end
        ST_SEND_STR: begin
          if (idx_r == str_len_r) begin
            state_r   <= ST_SEND_PAT;
            isstring  <= 1'b0;
            ispattern <= 1'b1;
            chardata  <= pat_buf_r[0];
            idx_r     <= 6'd1;
          end else begin
            chardata <= str_char_s;
            idx_r    <= idx_r + 6'd1;
          end
        end
        ST_SEND_PAT: begin
          if (idx_r == {2'b00, pat_len_r}) begin
            state_r   <= ST_WAIT;
            ispattern <= 1'b0;
            chardata  <= 8'd0;
            wdog_r    <= 10'd0;
          end else begin
            chardata <= pat_char_s;
            idx_r    <= idx_r + 6'd1;
          end
        end
        ST_WAIT: begin
          // An engine answer on the expiry edge still counts as a real result.
          if (valid) begin
            state_r     <= ST_REPORT;
            res_valid   <= 1'b1;
            res_match   <= match;
            res_index   <= match_index;
            res_timeout <= 1'b0;
          end else if (wdog_r == TIMEOUT_C) begin
            state_r     <= ST_REPORT;
            res_valid   <= 1'b1;
            res_match   <= 1'b0;
            res_index   <= 5'd0;
            res_timeout <= 1'b1;
          end else begin
            wdog_r <= wdog_r + 10'd1;
          end
        end
        ST_REPORT: begin
          state_r   <= ST_IDLE;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state_r   <= ST_IDLE;
          busy      <= 1'b0;
          isstring  <= 1'b0;
          ispattern <= 1'b0;
          chardata  <= 8'd0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sme_feeder.sv
// Bench for sme_feeder: directed and randomized jobs checked against a per-cycle
// expectation built from buffer contents and job lengths.
module tb_sme_feeder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic       wr_sel = 1'b0;
  logic [4:0] wr_addr = 5'd0;
  logic [7:0] wr_data = 8'd0;
  logic [5:0] str_len = 6'd0;
  logic [3:0] pat_len = 4'd0;
  logic       send_str = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid = 1'b0;
  logic       match = 1'b0;
  logic [4:0] match_index = 5'd0;
  logic       res_valid;
  logic       res_match;
  logic [4:0] res_index;
  logic       res_timeout;

  int tests = 0;
  int fails = 0;
  logic [7:0] str_m [32];
  logic [7:0] pat_m [8];

  sme_feeder #(.STR_MAX(32), .PAT_MAX(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .str_len(str_len), .pat_len(pat_len), .send_str(send_str),
    .start(start), .busy(busy), .chardata(chardata), .isstring(isstring),
    .ispattern(ispattern), .valid(valid), .match(match), .match_index(match_index),
    .res_valid(res_valid), .res_match(res_match), .res_index(res_index),
    .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".isstring"}, 32'(isstring), 32'd0);
    check({tag, ".ispattern"}, 32'(ispattern), 32'd0);
    check({tag, ".chardata"}, 32'(chardata), 32'd0);
    check({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".res_match"}, 32'(res_match), 32'd0);
    check({tag, ".res_index"}, 32'(res_index), 32'd0);
    check({tag, ".res_timeout"}, 32'(res_timeout), 32'd0);
  endtask

  task automatic wr(input bit sel, input logic [4:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    if (sel) pat_m[addr[2:0]] = data;
    else str_m[addr] = data;
    step();
    wr_en = 1'b0;
  endtask

  // d: WAIT cycle in which valid is driven (-1 = never); stray_k: stream cycle carrying a stray valid.
  task automatic run_job(input string tag, input int slen, input int plen, input bit sstr,
                         input int d, input bit m, input logic [4:0] mi, input int stray_k,
                         input bit noise, input bit co_wr, input logic [7:0] co_data);
    int L, n;
    bit got;
    logic [7:0] exp_c;
    L = (sstr && slen != 0) ? ((slen > 32) ? 32 : slen) : 0;
    str_len = 6'(slen); pat_len = 4'(plen); send_str = sstr; start = 1'b1;
    if (co_wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd0; wr_data = co_data;
      str_m[0] = co_data;
    end
    step();
    start = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= L + plen; k++) begin
      exp_c = (k <= L) ? str_m[k-1] : pat_m[k-L-1];
      check($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'd1);
      check($sformatf("%s.isstr%0d", tag, k), 32'(isstring), 32'(k <= L));
      check($sformatf("%s.ispat%0d", tag, k), 32'(ispattern), 32'(k > L));
      check($sformatf("%s.chr%0d", tag, k), 32'(chardata), 32'(exp_c));
      valid = (k == stray_k);
      match = 1'($urandom); match_index = 5'($urandom);
      if (noise) begin
        wr_en = 1'b1; wr_sel = 1'($urandom); wr_addr = 5'($urandom); wr_data = 8'($urandom);
        start = 1'b1; pat_len = 4'($urandom_range(1, 8)); send_str = 1'($urandom);
      end
      step();
    end
    valid = 1'b0; wr_en = 1'b0; start = 1'b0;
    check({tag, ".wait_flags"}, {30'd0, isstring, ispattern}, 32'd0);
    check({tag, ".wait_char"}, 32'(chardata), 32'd0);
    check({tag, ".wait_busy"}, 32'(busy), 32'd1);
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      valid = (n == d);
      if (n == d) begin
        match = m; match_index = mi;
      end else begin
        match = 1'($urandom); match_index = 5'($urandom);
      end
      step();
      n++;
      got = res_valid;
    end
    valid = 1'b0;
    check({tag, ".res_seen"}, 32'(got), 32'd1);
    check({tag, ".latency"}, 32'(n), (d >= 0) ? 32'(d + 1) : 32'(TO + 1));
    check({tag, ".res_match"}, 32'(res_match), (d >= 0) ? 32'(m) : 32'd0);
    check({tag, ".res_index"}, 32'(res_index), (d >= 0) ? 32'(mi) : 32'd0);
    check({tag, ".res_timeout"}, 32'(res_timeout), (d >= 0) ? 32'd0 : 32'd1);
    check({tag, ".rep_busy"}, 32'(busy), 32'd1);
    step();
    check({tag, ".pulse_end"}, 32'(res_valid), 32'd0);
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    string s;
    int d;
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, observed hang expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    string s;
    int d;
    // Reset state
    step(); step();
    check_all_zero("reset");
    reset = 1'b1;
    step();

    // Fill buffers completely, then "abcdefg" / "cde"
    for (int i = 0; i < 32; i++) wr(1'b0, 5'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) wr(1'b1, 5'(i), 8'($urandom));
    s = "abcdefg";
    for (int i = 0; i < 7; i++) wr(1'b0, 5'(i), s[i]);
    s = "cde";
    for (int i = 0; i < 3; i++) wr(1'b1, {2'($urandom), 3'(i)}, s[i]);
    run_job("basic", 7, 3, 1'b1, 2, 1'b1, 5'd2, -1, 1'b0, 1'b0, 8'd0);

    // Pattern-only follow-up
    s = "xyz";
    for (int i = 0; i < 3; i++) wr(1'b1, 5'(i), s[i]);
    run_job("patonly", 7, 3, 1'b0, 1, 1'b0, 5'd0, -1, 1'b0, 1'b0, 8'd0);

    // Engine never answers
    run_job("timeout", 5, 2, 1'b1, -1, 1'b0, 5'd0, -1, 1'b0, 1'b0, 8'd0);

    // Length clamp with a write on the start edge
    run_job("clamp", 40, 8, 1'b1, 3, 1'b1, 5'd17, -1, 1'b0, 1'b1, 8'($urandom));

    // send_str with zero string length behaves as pattern-only
    run_job("strlen0", 0, 4, 1'b1, 0, 1'b1, 5'd9, -1, 1'b0, 1'b0, 8'd0);

    // pat_len==0 start ignored
    pat_len = 4'd0; str_len = 6'd5; send_str = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("patlen0.busy", 32'(busy), 32'd0);
    check("patlen0.isstring", 32'(isstring), 32'd0);
    step();
    check("patlen0.busy2", 32'(busy), 32'd0);

    // start/wr_en noise while busy, then resend everything to show buffers untouched
    run_job("noise", 32, 8, 1'b1, 4, 1'b0, 5'd3, -1, 1'b1, 1'b0, 8'd0);
    run_job("persist", 32, 8, 1'b1, 1, 1'b1, 5'd31, -1, 1'b0, 1'b0, 8'd0);

    // Reset asserted on the fifth string char
    str_len = 6'd10; pat_len = 4'd3; send_str = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    check("rst.isstr5", 32'(isstring), 32'd1);
    check("rst.chr5", 32'(chardata), 32'(str_m[4]));
    reset = 1'b0;
    step();
    check_all_zero("rst_mid");
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("rst.noresult%0d", i), {30'd0, busy, res_valid}, 32'd0);
    end
    s = "cde";
    for (int i = 0; i < 3; i++) wr(1'b1, 5'(i), s[i]);
    run_job("after_rst", 7, 3, 1'b1, 2, 1'b1, 5'd2, -1, 1'b0, 1'b0, 8'd0);

    // Stray valid during pattern send, then real answer
    run_job("stray", 4, 5, 1'b1, 5, 1'b1, 5'd11, 6, 1'b0, 1'b0, 8'd0);
    // valid on the watchdog expiry edge
    run_job("tie", 3, 2, 1'b0, TO, 1'b1, 5'd7, -1, 1'b0, 1'b0, 8'd0);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      for (int w = 0; w < 4; w++) wr(1'($urandom), 5'($urandom), 8'($urandom));
      d = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO));
      run_job($sformatf("rnd%0d", j), int'($urandom_range(0, 63)), int'($urandom_range(1, 8)),
              1'($urandom), d, 1'($urandom), 5'($urandom), -1, 1'($urandom), 1'($urandom),
              8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
